// File: rtl/vram_dma.sv
// vram_dma: sprite-RAM DMA engine sitting between the CPU and the memory bus.
// While idle it passes CPU accesses through to the memory controller. A CPU
// write to the length register starts a block copy: each word is read from
// src, captured, and written to dst, with src/dst incrementing modulo 2^16.
// The CPU is stalled for the whole transfer.
//
// Optional feature macro: VRAM_DMA_VBLANK_WAIT_EN
//   When defined, reads only start while vbright is low (vertical blank);
//   the FSM parks in ARM while vbright is high.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cpu_memaddr/cpu_memwrite/cpu_writedata  CPU bus request
//   cpu_memdata        read data to CPU (STATUS register or memory data)
//   cpu_stall          high while a transfer owns the bus
//   memaddr/memwrite/writedata  bus to memory controller
//   memdata            read data from memory (one cycle after address)
//   vbright            high during the visible vertical region
module vram_dma #(
  parameter logic [15:0] SRC_REG_ADDR    = 16'h4804,
  parameter logic [15:0] DST_REG_ADDR    = 16'h4805,
  parameter logic [15:0] LEN_REG_ADDR    = 16'h4806,
  parameter logic [15:0] STATUS_REG_ADDR = 16'h4807
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_memaddr,
  input  logic        cpu_memwrite,
  input  logic [15:0] cpu_writedata,
  output logic [15:0] cpu_memdata,
  output logic        cpu_stall,
  output logic [15:0] memaddr,
  output logic        memwrite,
  output logic [15:0] writedata,
  input  logic [15:0] memdata,
  input  logic        vbright
);

  typedef enum logic [2:0] {IDLE, ARM, RD, CAP, WR} state_t;

  state_t      state;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] count;
  logic [15:0] data;
  logic        busy;
  logic        is_reg;
  logic        go_rd;

  assign busy   = (state != IDLE);
  assign is_reg = (cpu_memaddr == SRC_REG_ADDR) || (cpu_memaddr == DST_REG_ADDR) ||
                  (cpu_memaddr == LEN_REG_ADDR) || (cpu_memaddr == STATUS_REG_ADDR);

`ifdef VRAM_DMA_VBLANK_WAIT_EN
  // Reads may only begin outside the visible region.
  assign go_rd = !vbright;
`else
  logic unused_vbright;
  assign unused_vbright = vbright;
  assign go_rd = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      count <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_memwrite) begin
            if (cpu_memaddr == SRC_REG_ADDR) src <= cpu_writedata;
            if (cpu_memaddr == DST_REG_ADDR) dst <= cpu_writedata;
            if (cpu_memaddr == LEN_REG_ADDR && cpu_writedata != '0) begin
              count <= cpu_writedata;
              state <= ARM;
            end
          end
        end
        ARM: if (go_rd) state <= RD;
        RD:  state <= CAP;
        CAP: begin
          // Memory returns the RD-cycle address during CAP.
          data  <= memdata;
          state <= WR;
        end
        WR: begin
          src   <= src + 16'd1;
          dst   <= dst + 16'd1;
          count <= count - 16'd1;
          // A gated gap between words reuses ARM as the wait state.
          if (count == 16'd1) state <= IDLE;
          else if (go_rd)     state <= RD;
          else                state <= ARM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    memaddr   = cpu_memaddr;
    memwrite  = cpu_memwrite && !is_reg;
    writedata = cpu_writedata;
    case (state)
      ARM, RD, CAP: begin
        memaddr   = src;
        memwrite  = 1'b0;
        writedata = data;
      end
      WR: begin
        memaddr   = dst;
        memwrite  = 1'b1;
        writedata = data;
      end
      default: ;
    endcase
  end

  assign cpu_stall   = busy;
  assign cpu_memdata = (cpu_memaddr == STATUS_REG_ADDR) ? {15'b0, busy} : memdata;

endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: self-checking bench for vram_dma. Provides a 64K-word memory
// with one-cycle read latency, logs every bus write, and compares against a
// word-by-word copy model computed from the starting memory image.
module tb_vram_dma;

  localparam logic [15:0] SRC_A  = 16'h4804;
  localparam logic [15:0] DST_A  = 16'h4805;
  localparam logic [15:0] LEN_A  = 16'h4806;
  localparam logic [15:0] STAT_A = 16'h4807;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_memaddr = '0;
  logic        cpu_memwrite = 1'b0;
  logic [15:0] cpu_writedata = '0;
  logic [15:0] cpu_memdata;
  logic        cpu_stall;
  logic [15:0] memaddr;
  logic        memwrite;
  logic [15:0] writedata;
  logic [15:0] memdata;
  logic        vbright = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] wlog_a [$];
  logic [15:0] wlog_d [$];

  always #5 clk = ~clk;

  vram_dma #(
    .SRC_REG_ADDR(SRC_A), .DST_REG_ADDR(DST_A),
    .LEN_REG_ADDR(LEN_A), .STATUS_REG_ADDR(STAT_A)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_memaddr(cpu_memaddr), .cpu_memwrite(cpu_memwrite),
    .cpu_writedata(cpu_writedata), .cpu_memdata(cpu_memdata),
    .cpu_stall(cpu_stall), .memaddr(memaddr), .memwrite(memwrite),
    .writedata(writedata), .memdata(memdata), .vbright(vbright)
  );

  always @(posedge clk) begin
    if (memwrite) begin
      mem[memaddr] <= writedata;
      wlog_a.push_back(memaddr);
      wlog_d.push_back(writedata);
    end
    memdata <= mem[memaddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_memaddr = a; cpu_memwrite = 1'b1; cpu_writedata = d;
    @(negedge clk);
    cpu_memwrite = 1'b0; cpu_memaddr = '0;
  endtask

  // Counts busy cycles from the current negedge until cpu_stall drops.
  task automatic wait_idle(input int unsigned limit, output int unsigned cyc);
    cyc = 0;
    while (cpu_stall && cyc < limit) begin
      cyc++;
      @(negedge clk);
    end
    if (cpu_stall) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Expected write sequence for a copy, from the memory image before it starts.
  logic [15:0] exp_a [$];
  logic [15:0] exp_d [$];
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int unsigned n);
    logic [15:0] img [int];
    logic [15:0] v;
    exp_a.delete(); exp_d.delete();
    for (int unsigned i = 0; i < n; i++) begin
      int sa, da;
      sa = int'((s + i) % 65536);
      da = int'((d + i) % 65536);
      v = img.exists(sa) ? img[sa] : mem[sa];
      img[da] = v;
      exp_a.push_back(16'(da));
      exp_d.push_back(v);
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_nwr"}, wlog_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wlog_a.size(); i++) begin
      check({tag, "_waddr"}, wlog_a[i], exp_a[i]);
      check({tag, "_wdata"}, wlog_d[i], exp_d[i]);
    end
  endtask

  task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input int unsigned n);
    int unsigned cyc;
    cpu_wr(SRC_A, s);
    cpu_wr(DST_A, d);
    model_copy(s, d, n);
    wlog_a.delete(); wlog_d.delete();
    cpu_wr(LEN_A, 16'(n));
    wait_idle(3 * n + 20, cyc);
    check({tag, "_stall_cycles"}, cyc, 1 + 3 * n);
    compare_log(tag);
  endtask

  initial begin
    int unsigned cyc;
    logic [15:0] keep;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // Reset state and passthrough behaviour.
    #1;
    check("rst_stall", cpu_stall, 1'b0);
    cpu_memaddr = STAT_A; #1;
    check("rst_status", cpu_memdata, 16'h0000);
    @(negedge clk);
    cpu_memaddr = SRC_A; cpu_memwrite = 1'b1; #1;
    check("reg_addr_wr_blocked", memwrite, 1'b0);
    check("pass_addr", memaddr, SRC_A);
    cpu_memaddr = 16'h1234; cpu_writedata = 16'hBEEF; #1;
    check("pass_wr", memwrite, 1'b1);
    check("pass_wdata", writedata, 16'hBEEF);
    cpu_memwrite = 1'b0; cpu_memaddr = '0;
    @(negedge clk); rst = 1'b1;

    // Four-word copy with known contents.
    mem[16'h0100] = 16'hA0A0; mem[16'h0101] = 16'hB1B1;
    mem[16'h0102] = 16'hC2C2; mem[16'h0103] = 16'hD3D3;
    run_copy("basic4", 16'h0100, 16'h2000, 4);
    check("basic4_m0", mem[16'h2000], 16'hA0A0);
    check("basic4_m3", mem[16'h2003], 16'hD3D3);

    // Zero length does nothing.
    cpu_wr(SRC_A, 16'h0300); cpu_wr(DST_A, 16'h2100);
    wlog_a.delete(); wlog_d.delete();
    cpu_wr(LEN_A, 16'h0000);
    cyc = 0;
    repeat (10) begin
      if (cpu_stall) cyc++;
      @(negedge clk);
    end
    check("len0_stall", cyc, 0);
    check("len0_nwr", wlog_a.size(), 0);

    // Source address wraps.
    run_copy("wrap", 16'hFFFF, 16'h2400, 2);
    check("wrap_m1", mem[16'h2401], mem[16'h0000]);

    // Status poll and ignored CPU writes during a transfer.
    cpu_wr(SRC_A, 16'h0500); cpu_wr(DST_A, 16'h2800);
    model_copy(16'h0500, 16'h2800, 4);
    wlog_a.delete(); wlog_d.delete();
    cpu_wr(LEN_A, 16'd4);
    @(negedge clk);
    cpu_memaddr = STAT_A; #1;
    check("busy_status", cpu_memdata, 16'h0001);
    cpu_memaddr = 16'h4803; cpu_memwrite = 1'b1; cpu_writedata = 16'h5555;
    repeat (2) @(negedge clk);
    cpu_memaddr = SRC_A; cpu_writedata = 16'h7777;
    repeat (2) @(negedge clk);
    cpu_memwrite = 1'b0; cpu_memaddr = '0;
    wait_idle(40, cyc);
    cpu_memaddr = STAT_A; #1;
    check("done_status", cpu_memdata, 16'h0000);
    compare_log("busy");
    // Pointers were left one past the last word and SRC was not overwritten.
    model_copy(16'h0504, 16'h2804, 1);
    wlog_a.delete(); wlog_d.delete();
    cpu_wr(LEN_A, 16'd1);
    wait_idle(20, cyc);
    check("cont_cycles", cyc, 4);
    compare_log("cont");

    // Randomised copies, some overlapping in ascending direction.
    for (int t = 0; t < 6; t++) begin
      logic [15:0] s, d;
      int unsigned n;
      s = 16'($urandom_range(16'h0000, 16'h3FFF));
      n = $urandom_range(1, 12);
      d = (t % 2 == 0) ? 16'(s + $urandom_range(1, 3)) : 16'($urandom_range(16'h8000, 16'hBFFF));
      run_copy($sformatf("rand%0d", t), s, d, n);
    end

    // Reset during the second write of a four-word copy.
    cpu_wr(SRC_A, 16'h0600); cpu_wr(DST_A, 16'h2C00);
    keep = mem[16'h2C01];
    wlog_a.delete(); wlog_d.delete();
    cpu_wr(LEN_A, 16'd4);
    repeat (6) @(negedge clk);
    check("rst_mid_wr_active", memwrite, 1'b1);
    rst = 1'b0; #1;
    check("rst_mid_memwrite", memwrite, 1'b0);
    check("rst_mid_stall", cpu_stall, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_nwr", wlog_a.size(), 1);
    check("rst_mid_word0", mem[16'h2C00], mem[16'h0600]);
    check("rst_mid_word1_kept", mem[16'h2C01], keep);
    cpu_memaddr = STAT_A; #1;
    check("rst_mid_status", cpu_memdata, 16'h0000);
    cpu_memaddr = '0;

`ifdef VRAM_DMA_VBLANK_WAIT_EN
    // Gated start: nothing moves while vbright is high.
    vbright = 1'b1;
    cpu_wr(SRC_A, 16'h0700); cpu_wr(DST_A, 16'h3000);
    model_copy(16'h0700, 16'h3000, 1);
    wlog_a.delete(); wlog_d.delete();
    cpu_wr(LEN_A, 16'd1);
    repeat (20) @(negedge clk);
    check("vb_hold_nwr", wlog_a.size(), 0);
    check("vb_hold_stall", cpu_stall, 1'b1);
    vbright = 1'b0;
    wait_idle(20, cyc);
    check("vb_release_cycles", cyc, 4);
    compare_log("vb");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_dma.md
VRAM_DMA -- requirements
Module: vram_dma

Interface
REQ-001 SHALL have parameter SRC_REG_ADDR, default 16'h4804, the CPU-visible address of the DMA source register.
REQ-002 SHALL have parameter DST_REG_ADDR, default 16'h4805, the CPU-visible address of the DMA destination register.
REQ-003 SHALL have parameter LEN_REG_ADDR, default 16'h4806; a write to this address starts the transfer.
REQ-004 SHALL have parameter STATUS_REG_ADDR, default 16'h4807, the read-only busy flag.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cpu_memaddr  in  16  CPU data address.
REQ-008 cpu_memwrite  in  1  CPU write strobe.
REQ-009 cpu_writedata  in  16  CPU write data.
REQ-010 cpu_memdata  out  16  read data returned to the CPU.
REQ-011 cpu_stall  out  1  high while a transfer owns the bus.
REQ-012 memaddr  out  16, memwrite  out  1, writedata  out  16: bus to the memory controller.
REQ-013 memdata  in  16  read data from the memory controller; program memory returns it one cycle after the address is presented.
REQ-014 vbright  in  1  high during the visible vertical region.

Function
REQ-015 IDLE: memaddr, memwrite and writedata SHALL pass cpu_memaddr, cpu_memwrite and cpu_writedata through combinationally.
- One exception: memwrite SHALL be forced to 0 when cpu_memaddr equals one of the four register addresses.
REQ-016 A CPU write to SRC_REG_ADDR or DST_REG_ADDR in IDLE SHALL load the 16-bit register on that edge.
REQ-017 A CPU write to LEN_REG_ADDR in IDLE with nonzero data SHALL load the count and move to ARM on the same edge.
- Write data 0 SHALL load nothing and remain IDLE.
REQ-018 cpu_memdata SHALL be {15'b0, busy} when cpu_memaddr == STATUS_REG_ADDR, otherwise memdata.
- busy = state != IDLE.
REQ-019 cpu_stall SHALL equal busy; while busy, all cpu_* inputs SHALL be ignored and no register SHALL change from CPU writes.
REQ-020 The FSM SHALL have exactly five states: IDLE, ARM, RD, CAP, WR.
- ARM -> RD after one cycle.
- RD (memaddr=src, memwrite=0) -> CAP.
- CAP (memaddr=src, memwrite=0): memdata captured into the data register at the end of the cycle -> WR.
- WR (memaddr=dst, memwrite=1, writedata=captured data): src+1, dst+1, count-1.
- WR -> IDLE if the old count was 1, else -> RD.
REQ-021 Each word SHALL take exactly 3 cycles; total busy time SHALL be 1 + 3*N cycles for length N (without the macro).
REQ-022 src and dst increments SHALL be modulo 2^16 (16'hFFFF wraps to 16'h0000); count is a 16-bit unsigned value, so the maximum transfer is 65535 words.
REQ-023 Overlapping ranges SHALL be copied in ascending address order with no hazard protection.
REQ-024 On completion, src and dst SHALL hold the address one past the last word (readback not provided), count SHALL be 0, and cpu_stall SHALL drop in the cycle after the final WR.

Reset
REQ-025 rst low SHALL asynchronously force IDLE and clear src, dst, count and the data register to 0.
REQ-026 Reset mid-transfer SHALL abort immediately: memwrite and cpu_stall low with no further writes, and already-written words remain.

Configuration
REQ-027 Macro VRAM_DMA_VBLANK_WAIT_EN controls vertical-blank gating.
- Defined: ARM SHALL hold, and RD SHALL not be entered from WR, while vbright==1; the FSM waits in ARM, or in a WR-to-RD gap modelled as ARM, until vbright==0.
- Undefined: vbright SHALL be ignored and the timing of REQ-021 SHALL apply.

Verification
REQ-028 Without the macro: preload program words at 0x0100..0x0103 = A,B,C,D; write SRC=0x0100, DST=0x2000, LEN=4 -> sprite RAM 0x2000..0x2003 = A..D, cpu_stall high for exactly 13 cycles.
REQ-029 Write LEN=0 -> cpu_stall never asserts and no memwrite pulse occurs.
REQ-030 Set SRC=0xFFFF, DST=0x2400, LEN=2 -> reads from 0xFFFF then 0x0000; writes to 0x2400 then 0x2401.
REQ-031 During a transfer, poll STATUS (reads 1) and drive a CPU write to 0x4803 -> no memwrite to 0x4803, SRC unchanged; STATUS reads 0 after completion.
REQ-032 Assert rst during the second WR of LEN=4 -> memwrite low within the same cycle, exactly 1 word written, state IDLE.
REQ-033 With the macro, holding vbright=1 for 20 cycles after LEN=1 -> no bus activity until vbright falls; the copy completes 3 cycles later.
